seg_scan_decoder: RTL

//   Reads the 2-digit multiplexed seven-segment bus (seg/seg_on) driven by the button counter and

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Seven-segment scan bus plus the recovered-digit outputs of the scan decoder.
interface seg_scan_if;
    logic [7:0] seg_in;
    logic [1:0] seg_on_in;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       valid;
    logic       update;
    logic       pat_err;
    logic       sel_err;
    logic       stale;

    modport master (
        output seg_in, seg_on_in,
        input  tens, ones, valid, update, pat_err, sel_err, stale
    );

    modport slave (
        input  seg_in, seg_on_in,
        output tens, ones, valid, update, pat_err, sel_err, stale
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the two digits shown on a multiplexed seven-segment bus, with glitch
// filtering per digit and detection of a stalled scan.
module seg_scan_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int SEL_LAG     = 1,
    parameter int STABLE_CNT  = 2,
    parameter int TIMEOUT     = 200000
) (
    input logic      clk,
    input logic      rst,
    seg_scan_if.slave bus
);

    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0] CNT_MAX   = 4'(STABLE_CNT);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    logic [SYNC_STAGES-1:0][7:0] seg_sync_q, seg_sync_d;
    logic [SYNC_STAGES-1:0][1:0] sel_sync_q, sel_sync_d;
    logic [7:0]    seg_prev_q, seg_prev_d;
    logic [1:0]    sel_prev_q, sel_prev_d;
    logic [1:0][3:0] cand_q, cand_d;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic [1:0][3:0] out_q, out_d;
    logic [1:0]    seen_q, seen_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          stale_q, stale_d;
    logic          update_q, update_d;
    logic          pat_err_q, pat_err_d;
    logic          sel_err_q, sel_err_d;

    logic [7:0] s_seg;
    logic [1:0] s_sel;
    logic       slot_end;
    logic [7:0] seg_key;
    logic       dec_hit;
    logic [3:0] dec_val;
    logic       dig;

    assign s_seg    = seg_sync_q[SYNC_STAGES-1];
    assign s_sel    = sel_sync_q[SYNC_STAGES-1];
    assign slot_end = (s_sel != sel_prev_q);
    assign seg_key  = seg_prev_q & 8'hFE;

    always_comb begin
        seg_sync_d = {seg_sync_q[SYNC_STAGES-2:0], bus.seg_in};
        sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], bus.seg_on_in};
        seg_prev_d = s_seg;
        sel_prev_d = s_sel;
    end

    // Decimal point (bit 0) is masked off before lookup.
    always_comb begin
        dec_hit = 1'b1;
        dec_val = 4'h0;
        case (seg_key)
            8'hFC: dec_val = 4'h0;
            8'h60: dec_val = 4'h1;
            8'hDA: dec_val = 4'h2;
            8'hF2: dec_val = 4'h3;
            8'h66: dec_val = 4'h4;
            8'hB6: dec_val = 4'h5;
            8'hBE: dec_val = 4'h6;
            8'hE0: dec_val = 4'h7;
            8'hFE: dec_val = 4'h8;
            8'hF6: dec_val = 4'h9;
            8'hEE: dec_val = 4'hA;
            8'h3E: dec_val = 4'hB;
            8'h9C: dec_val = 4'hC;
            8'h7A: dec_val = 4'hD;
            8'h9E: dec_val = 4'hE;
            8'h8E: dec_val = 4'hF;
            default: dec_hit = 1'b0;
        endcase
    end

    // Digit index: 1 = tens, 0 = ones. With SEL_LAG the pattern trails the select by one digit.
    always_comb begin
        dig = 1'b0;
        if (sel_prev_q == 2'b10) dig = (SEL_LAG != 0) ? 1'b0 : 1'b1;
        if (sel_prev_q == 2'b01) dig = (SEL_LAG != 0) ? 1'b1 : 1'b0;
    end

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        seen_d    = seen_q;
        timer_d   = timer_q;
        stale_d   = stale_q;
        update_d  = 1'b0;
        pat_err_d = 1'b0;
        sel_err_d = 1'b0;
        if (slot_end) begin
            timer_d = '0;
            stale_d = 1'b0;
            if (sel_prev_q == 2'b10 || sel_prev_q == 2'b01) begin
                if (!dec_hit) begin
                    pat_err_d  = 1'b1;
                    cnt_d[dig] = 4'd0;
                end else begin
                    if (dec_val == cand_q[dig]) begin
                        if (cnt_q[dig] != CNT_MAX) cnt_d[dig] = cnt_q[dig] + 4'd1;
                    end else begin
                        cand_d[dig] = dec_val;
                        cnt_d[dig]  = 4'd1;
                    end
                    if (cnt_d[dig] == CNT_MAX) begin
                        seen_d[dig] = 1'b1;
                        out_d[dig]  = cand_d[dig];
                        update_d    = (cand_d[dig] != out_q[dig]);
                    end
                end
            end else begin
                sel_err_d = 1'b1;
            end
        end else begin
            if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
            // Stalled scan: forget acceptance so both digits must be re-confirmed.
            if (timer_d == TIMER_MAX) begin
                stale_d = 1'b1;
                seen_d  = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_sync_q <= '0;
            sel_sync_q <= '0;
            seg_prev_q <= '0;
            sel_prev_q <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            seen_q     <= '0;
            timer_q    <= '0;
            stale_q    <= 1'b0;
            update_q   <= 1'b0;
            pat_err_q  <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            seg_sync_q <= seg_sync_d;
            sel_sync_q <= sel_sync_d;
            seg_prev_q <= seg_prev_d;
            sel_prev_q <= sel_prev_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            seen_q     <= seen_d;
            timer_q    <= timer_d;
            stale_q    <= stale_d;
            update_q   <= update_d;
            pat_err_q  <= pat_err_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.tens    = out_q[1];
    assign bus.ones    = out_q[0];
    assign bus.valid   = seen_q[1] & seen_q[0] & ~stale_q;
    assign bus.update  = update_q;
    assign bus.pat_err = pat_err_q;
    assign bus.sel_err = sel_err_q;
    assign bus.stale   = stale_q;

endmodule
